// File: rtl/link_token_fifo_if.sv
// Link-side bundle for link_token_fifo: TX handshake toward the link and RX
// token delivery from the link. The slave modport is the endpoint's view;
// the master modport is the view of whatever drives and observes it.
interface link_token_fifo_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 32
);
   logic             i_wen_to_link;
   logic [WIDTH-1:0] i_token_to_link;
   logic             o_full_to_link;
   logic             o_overflow;
   logic             o_wen_to_link;
   logic             i_ready_to_link;
   logic [WIDTH-1:0] o_token_to_link;
   logic [CNT_W-1:0] o_clk_cnt_to_link;
   logic [31:0]      o_id_to_link;
   logic             i_wen_from_link;
   logic [WIDTH-1:0] i_token_from_link;
   logic [CNT_W-1:0] i_clk_cnt_from_link;
   logic [31:0]      i_id_from_link;
   logic             o_wen_from_link;
   logic [WIDTH-1:0] o_token_from_link;
   logic [CNT_W-1:0] o_clk_cnt_from_link;
   logic [15:0]      o_drop_cnt;
   logic [CNT_W-1:0] o_clk_cnt;

   modport slave (
      input  i_wen_to_link, i_token_to_link, i_ready_to_link,
      input  i_wen_from_link, i_token_from_link, i_clk_cnt_from_link, i_id_from_link,
      output o_full_to_link, o_overflow, o_wen_to_link, o_token_to_link,
      output o_clk_cnt_to_link, o_id_to_link, o_wen_from_link, o_token_from_link,
      output o_clk_cnt_from_link, o_drop_cnt, o_clk_cnt
   );

   modport master (
      output i_wen_to_link, i_token_to_link, i_ready_to_link,
      output i_wen_from_link, i_token_from_link, i_clk_cnt_from_link, i_id_from_link,
      input  o_full_to_link, o_overflow, o_wen_to_link, o_token_to_link,
      input  o_clk_cnt_to_link, o_id_to_link, o_wen_from_link, o_token_from_link,
      input  o_clk_cnt_from_link, o_drop_cnt, o_clk_cnt
   );
endinterface

// File: rtl/link_token_fifo.sv
// Link endpoint for the dist_sim fabric.
// TX: local tokens are stamped with the free-running clock count and queued
// in a DEPTH-entry first-word-fall-through FIFO drained by valid/ready.
// RX: one register stage, tokens filtered by destination ID, mismatches
// counted in a saturating 16-bit drop counter.
// Optional feature: define LINK_TOKEN_FIFO_BCAST_EN to also accept the
// all-ones destination ID as a broadcast.
module link_token_fifo #(
   parameter int          WIDTH = 32,
   parameter int          DEPTH = 8,
   parameter int          CNT_W = 32,
   parameter logic [31:0] ID    = 32'h0
) (
   input logic              i_clk_to_link,
   input logic              i_rstn_to_link,
   link_token_fifo_if.slave lnk
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = WIDTH + CNT_W;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [CNT_W-1:0] clk_cnt;
   logic [EW-1:0]    mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             overflow;
   logic             full;
   logic             valid;
   logic             push;
   logic             pop;
   logic [EW-1:0]    head;

   logic             id_hit;
   logic             rx_acc;
   logic             rx_drop;
   logic             rx_wen;
   logic [WIDTH-1:0] rx_token;
   logic [CNT_W-1:0] rx_clk_cnt;
   logic [15:0]      drop_cnt;

   assign full  = (count == FULL_CNT);
   assign valid = (count != '0);
   // A write while full is refused even if the head pops in the same cycle.
   assign push  = lnk.i_wen_to_link && !full;
   assign pop   = valid && lnk.i_ready_to_link;
   assign head  = mem[rd_ptr];

   // Free-running local clock count, wraps naturally at 2^CNT_W.
   always_ff @(posedge i_clk_to_link) begin
      if (!i_rstn_to_link) clk_cnt <= '0;
      else                 clk_cnt <= clk_cnt + 1'b1;
   end

   // FIFO storage: stale contents are harmless because the head is gated by valid.
   always_ff @(posedge i_clk_to_link) begin
      if (push) mem[wr_ptr] <= {lnk.i_token_to_link, clk_cnt};
   end

   // FIFO pointers, fill count and sticky overflow flag.
   always_ff @(posedge i_clk_to_link) begin
      if (!i_rstn_to_link) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (lnk.i_wen_to_link && full) overflow <= 1'b1;
      end
   end

   // Destination filter; the broadcast ID is only special when enabled.
   always_comb begin
      id_hit = (lnk.i_id_from_link == ID);
`ifdef LINK_TOKEN_FIFO_BCAST_EN
      id_hit = id_hit || (lnk.i_id_from_link == 32'hFFFF_FFFF);
`else
      id_hit = id_hit;
`endif
   end

   assign rx_acc  = lnk.i_wen_from_link && id_hit;
   assign rx_drop = lnk.i_wen_from_link && !id_hit;

   // RX register stage and saturating drop counter.
   always_ff @(posedge i_clk_to_link) begin
      if (!i_rstn_to_link) begin
         rx_wen     <= 1'b0;
         rx_token   <= '0;
         rx_clk_cnt <= '0;
         drop_cnt   <= '0;
      end else begin
         rx_wen <= rx_acc;
         if (rx_acc) begin
            rx_token   <= lnk.i_token_from_link;
            rx_clk_cnt <= lnk.i_clk_cnt_from_link;
         end
         if (rx_drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      end
   end

   assign lnk.o_full_to_link      = full;
   assign lnk.o_overflow          = overflow;
   assign lnk.o_wen_to_link       = valid;
   assign lnk.o_token_to_link     = valid ? head[EW-1:CNT_W] : '0;
   assign lnk.o_clk_cnt_to_link   = valid ? head[CNT_W-1:0] : '0;
   assign lnk.o_id_to_link        = ID;
   assign lnk.o_wen_from_link     = rx_wen;
   assign lnk.o_token_from_link   = rx_token;
   assign lnk.o_clk_cnt_from_link = rx_clk_cnt;
   assign lnk.o_drop_cnt          = drop_cnt;
   assign lnk.o_clk_cnt           = clk_cnt;
endmodule

// File: tb/tb_link_token_fifo.sv
// Self-checking bench for link_token_fifo: TX ordering, stamps, full and
// overflow behaviour, streaming push+pop, RX filtering, mid-operation reset
// and clock-count wrap on a narrow-counter instance.
module tb_link_token_fifo;
   localparam int          WIDTH = 32;
   localparam int          CNT_W = 32;
   localparam int          DEPTH = 8;
   localparam logic [31:0] ID    = 32'h0000_0005;
`ifdef LINK_TOKEN_FIFO_BCAST_EN
   localparam bit BCAST = 1'b1;
`else
   localparam bit BCAST = 1'b0;
`endif

   logic clk;
   logic rstn;
   int   checks;
   int   errors;
   logic [31:0] model_cnt;

   logic [WIDTH+CNT_W-1:0] tx_q [$];
   logic [WIDTH+CNT_W-1:0] rx_q [$];
   logic [WIDTH+CNT_W-1:0] exp_e;

   link_token_fifo_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) lnk ();
   link_token_fifo_if #(.WIDTH(WIDTH), .CNT_W(4))     lnk4 ();

   link_token_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W), .ID(ID)) dut (
      .i_clk_to_link  (clk),
      .i_rstn_to_link (rstn),
      .lnk            (lnk)
   );

   link_token_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(4), .ID(ID)) dut4 (
      .i_clk_to_link  (clk),
      .i_rstn_to_link (rstn),
      .lnk            (lnk4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference clock count, reset synchronously like the endpoint.
   always @(posedge clk) model_cnt <= rstn ? model_cnt + 32'd1 : 32'd0;

   task automatic idle_inputs();
      lnk.i_wen_to_link       = 1'b0;
      lnk.i_token_to_link     = '0;
      lnk.i_ready_to_link     = 1'b0;
      lnk.i_wen_from_link     = 1'b0;
      lnk.i_token_from_link   = '0;
      lnk.i_clk_cnt_from_link = '0;
      lnk.i_id_from_link      = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      tx_q.delete();
      rx_q.delete();
   endtask

   task automatic test_reset();
      idle_inputs();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      checks++; if (lnk.o_clk_cnt !== 32'd0) begin errors++; $display("FAIL reset_clk_cnt got %0h want 0", lnk.o_clk_cnt); end
      checks++; if (lnk.o_wen_to_link !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %0b want 0", lnk.o_wen_to_link); end
      checks++; if (lnk.o_full_to_link !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", lnk.o_full_to_link); end
      checks++; if (lnk.o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", lnk.o_overflow); end
      checks++; if ({lnk.o_token_to_link, lnk.o_clk_cnt_to_link} !== 64'd0) begin errors++; $display("FAIL reset_tx_head got %0h want 0", {lnk.o_token_to_link, lnk.o_clk_cnt_to_link}); end
      checks++; if (lnk.o_wen_from_link !== 1'b0) begin errors++; $display("FAIL reset_rx_wen got %0b want 0", lnk.o_wen_from_link); end
      checks++; if ({lnk.o_token_from_link, lnk.o_clk_cnt_from_link} !== 64'd0) begin errors++; $display("FAIL reset_rx_data got %0h want 0", {lnk.o_token_from_link, lnk.o_clk_cnt_from_link}); end
      checks++; if (lnk.o_drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt got %0h want 0", lnk.o_drop_cnt); end
      checks++; if (lnk.o_id_to_link !== ID) begin errors++; $display("FAIL reset_id got %0h want %0h", lnk.o_id_to_link, ID); end
      repeat (4) @(negedge clk);
      checks++; if (lnk.o_clk_cnt !== 32'd4) begin errors++; $display("FAIL idle_clk_cnt got %0d want 4", lnk.o_clk_cnt); end
      checks++; if (lnk.o_wen_to_link !== 1'b0) begin errors++; $display("FAIL idle_tx_valid got %0b want 0", lnk.o_wen_to_link); end
   endtask

   task automatic test_fifo_order();
      logic [WIDTH-1:0] toks [3];
      toks[0] = 32'hA; toks[1] = 32'hB; toks[2] = 32'hC;
      tx_q.delete();
      lnk.i_ready_to_link = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 1) begin
            checks++; if (lnk.o_wen_to_link !== 1'b1) begin errors++; $display("FAIL write_latency got %0b want 1", lnk.o_wen_to_link); end
         end
         lnk.i_wen_to_link   = 1'b1;
         lnk.i_token_to_link = toks[i];
         tx_q.push_back({toks[i], model_cnt});
      end
      @(negedge clk);
      lnk.i_wen_to_link = 1'b0;
      repeat (2) @(negedge clk);
      exp_e = tx_q[0];
      checks++; if (lnk.o_token_to_link !== exp_e[63:32]) begin errors++; $display("FAIL head_hold got %0h want %0h", lnk.o_token_to_link, exp_e[63:32]); end
      for (int i = 0; i < 3; i++) begin
         exp_e = tx_q.pop_front();
         checks++; if (lnk.o_wen_to_link !== 1'b1) begin errors++; $display("FAIL order_valid[%0d] got %0b want 1", i, lnk.o_wen_to_link); end
         checks++; if ({lnk.o_token_to_link, lnk.o_clk_cnt_to_link} !== exp_e) begin errors++; $display("FAIL order_head[%0d] got %0h want %0h", i, {lnk.o_token_to_link, lnk.o_clk_cnt_to_link}, exp_e); end
         lnk.i_ready_to_link = 1'b1;
         @(negedge clk);
      end
      lnk.i_ready_to_link = 1'b0;
      checks++; if (lnk.o_wen_to_link !== 1'b0) begin errors++; $display("FAIL order_valid_fall got %0b want 0", lnk.o_wen_to_link); end
   endtask

   task automatic test_full_overflow();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         lnk.i_wen_to_link   = 1'b1;
         lnk.i_token_to_link = 32'h100 + i;
         if (i < 8) tx_q.push_back({32'h100 + i, model_cnt});
         @(negedge clk);
         if (i == 7) begin
            checks++; if (lnk.o_full_to_link !== 1'b1) begin errors++; $display("FAIL full_after_8 got %0b want 1", lnk.o_full_to_link); end
            checks++; if (lnk.o_overflow !== 1'b0) begin errors++; $display("FAIL no_overflow_yet got %0b want 0", lnk.o_overflow); end
         end
      end
      lnk.i_wen_to_link = 1'b0;
      checks++; if (lnk.o_overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got %0b want 1", lnk.o_overflow); end
      checks++; if (lnk.o_full_to_link !== 1'b1) begin errors++; $display("FAIL full_held got %0b want 1", lnk.o_full_to_link); end
      for (int i = 0; i < 8; i++) begin
         exp_e = tx_q.pop_front();
         checks++; if ({lnk.o_wen_to_link, lnk.o_token_to_link, lnk.o_clk_cnt_to_link} !== {1'b1, exp_e}) begin errors++; $display("FAIL full_drain[%0d] got %0h want %0h", i, {lnk.o_wen_to_link, lnk.o_token_to_link, lnk.o_clk_cnt_to_link}, {1'b1, exp_e}); end
         if (i == 7) begin
            checks++; if (lnk.o_token_to_link !== 32'h107) begin errors++; $display("FAIL last_token got %0h want 107", lnk.o_token_to_link); end
         end
         lnk.i_ready_to_link = 1'b1;
         @(negedge clk);
      end
      lnk.i_ready_to_link = 1'b0;
      checks++; if (lnk.o_wen_to_link !== 1'b0) begin errors++; $display("FAIL full_drain_empty got %0b want 0", lnk.o_wen_to_link); end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         lnk.i_wen_to_link   = 1'b1;
         lnk.i_token_to_link = 32'h200 + i;
         tx_q.push_back({32'h200 + i, model_cnt});
         @(negedge clk);
      end
      exp_e = tx_q.pop_front();
      checks++; if ({lnk.o_token_to_link, lnk.o_clk_cnt_to_link} !== exp_e) begin errors++; $display("FAIL pp_head got %0h want %0h", {lnk.o_token_to_link, lnk.o_clk_cnt_to_link}, exp_e); end
      lnk.i_wen_to_link   = 1'b1;
      lnk.i_token_to_link = 32'h2FF;
      lnk.i_ready_to_link = 1'b1;
      @(negedge clk);
      lnk.i_wen_to_link   = 1'b0;
      lnk.i_ready_to_link = 1'b0;
      checks++; if (lnk.o_overflow !== 1'b1) begin errors++; $display("FAIL pp_overflow got %0b want 1", lnk.o_overflow); end
      checks++; if (lnk.o_full_to_link !== 1'b0) begin errors++; $display("FAIL pp_not_full got %0b want 0", lnk.o_full_to_link); end
      for (int i = 0; i < 7; i++) begin
         exp_e = tx_q.pop_front();
         checks++; if ({lnk.o_wen_to_link, lnk.o_token_to_link, lnk.o_clk_cnt_to_link} !== {1'b1, exp_e}) begin errors++; $display("FAIL pp_drain[%0d] got %0h want %0h", i, {lnk.o_wen_to_link, lnk.o_token_to_link, lnk.o_clk_cnt_to_link}, {1'b1, exp_e}); end
         lnk.i_ready_to_link = 1'b1;
         @(negedge clk);
      end
      lnk.i_ready_to_link = 1'b0;
      checks++; if (lnk.o_wen_to_link !== 1'b0) begin errors++; $display("FAIL pp_count7 got valid %0b want 0", lnk.o_wen_to_link); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      lnk.i_ready_to_link = 1'b1;
      for (int c = 0; c < 10; c++) begin
         checks++; if (lnk.o_wen_to_link !== (tx_q.size() != 0)) begin errors++; $display("FAIL b2b_valid[%0d] got %0b want %0b", c, lnk.o_wen_to_link, tx_q.size() != 0); end
         if (lnk.o_wen_to_link === 1'b1 && tx_q.size() != 0) begin
            exp_e = tx_q.pop_front();
            checks++; if ({lnk.o_token_to_link, lnk.o_clk_cnt_to_link} !== exp_e) begin errors++; $display("FAIL b2b_head[%0d] got %0h want %0h", c, {lnk.o_token_to_link, lnk.o_clk_cnt_to_link}, exp_e); end
         end
         if (c < 6) begin
            lnk.i_wen_to_link   = 1'b1;
            lnk.i_token_to_link = 32'h300 + c;
            tx_q.push_back({32'h300 + c, model_cnt});
         end else begin
            lnk.i_wen_to_link = 1'b0;
         end
         @(negedge clk);
      end
      lnk.i_ready_to_link = 1'b0;
      checks++; if (tx_q.size() != 0) begin errors++; $display("FAIL b2b_leftover got %0d want 0", tx_q.size()); end
   endtask

   task automatic test_rx();
      logic [WIDTH-1:0] exp_tok;
      logic [15:0]      exp_drop;
      do_reset();
      lnk.i_wen_from_link     = 1'b1;
      lnk.i_id_from_link      = ID;
      lnk.i_token_from_link   = 32'h55;
      lnk.i_clk_cnt_from_link = 32'h1234;
      rx_q.push_back({32'h55, 32'h1234});
      @(negedge clk);
      lnk.i_wen_from_link = 1'b0;
      exp_e = rx_q.pop_front();
      checks++; if (lnk.o_wen_from_link !== 1'b1) begin errors++; $display("FAIL rx_pulse got %0b want 1", lnk.o_wen_from_link); end
      checks++; if ({lnk.o_token_from_link, lnk.o_clk_cnt_from_link} !== exp_e) begin errors++; $display("FAIL rx_data got %0h want %0h", {lnk.o_token_from_link, lnk.o_clk_cnt_from_link}, exp_e); end
      @(negedge clk);
      checks++; if ({lnk.o_wen_from_link, lnk.o_token_from_link} !== {1'b0, 32'h55}) begin errors++; $display("FAIL rx_pulse_end got %0h want 55", {lnk.o_wen_from_link, lnk.o_token_from_link}); end
      lnk.i_wen_from_link   = 1'b1;
      lnk.i_id_from_link    = ID + 32'd1;
      lnk.i_token_from_link = 32'h66;
      @(negedge clk);
      lnk.i_wen_from_link = 1'b0;
      checks++; if (lnk.o_wen_from_link !== 1'b0) begin errors++; $display("FAIL rx_mismatch_pulse got %0b want 0", lnk.o_wen_from_link); end
      checks++; if (lnk.o_drop_cnt !== 16'd1) begin errors++; $display("FAIL rx_drop1 got %0d want 1", lnk.o_drop_cnt); end
      checks++; if (lnk.o_token_from_link !== 32'h55) begin errors++; $display("FAIL rx_hold got %0h want 55", lnk.o_token_from_link); end
      lnk.i_wen_from_link   = 1'b1;
      lnk.i_id_from_link    = 32'hFFFF_FFFF;
      lnk.i_token_from_link = 32'h77;
      if (BCAST) rx_q.push_back({32'h77, 32'h1234});
      exp_tok  = BCAST ? 32'h77 : 32'h55;
      exp_drop = BCAST ? 16'd1 : 16'd2;
      @(negedge clk);
      lnk.i_wen_from_link = 1'b0;
      checks++; if (lnk.o_wen_from_link !== (rx_q.size() != 0)) begin errors++; $display("FAIL rx_bcast_pulse got %0b want %0b", lnk.o_wen_from_link, rx_q.size() != 0); end
      checks++; if (lnk.o_token_from_link !== exp_tok) begin errors++; $display("FAIL rx_bcast_token got %0h want %0h", lnk.o_token_from_link, exp_tok); end
      checks++; if (lnk.o_drop_cnt !== exp_drop) begin errors++; $display("FAIL rx_bcast_drop got %0d want %0d", lnk.o_drop_cnt, exp_drop); end
      rx_q.delete();
      idle_inputs();
   endtask

   task automatic test_reset_midop();
      lnk.i_ready_to_link = 1'b0;
      for (int i = 0; i < 4; i++) begin
         lnk.i_wen_to_link   = 1'b1;
         lnk.i_token_to_link = 32'h400 + i;
         @(negedge clk);
      end
      lnk.i_wen_to_link = 1'b0;
      checks++; if (lnk.o_wen_to_link !== 1'b1) begin errors++; $display("FAIL midop_queued got %0b want 1", lnk.o_wen_to_link); end
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      tx_q.delete();
      checks++; if (lnk.o_wen_to_link !== 1'b0) begin errors++; $display("FAIL midop_empty got %0b want 0", lnk.o_wen_to_link); end
      checks++; if (lnk.o_clk_cnt !== 32'd0) begin errors++; $display("FAIL midop_clk_cnt got %0h want 0", lnk.o_clk_cnt); end
      @(negedge clk);
      checks++; if (lnk.o_wen_to_link !== 1'b0) begin errors++; $display("FAIL midop_stays_empty got %0b want 0", lnk.o_wen_to_link); end
   endtask

   task automatic test_wrap();
      bit found;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         if (lnk4.o_clk_cnt === 4'd15) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL wrap_reach15 got timeout want 15"); end
      @(negedge clk);
      checks++; if (lnk4.o_clk_cnt !== 4'd0) begin errors++; $display("FAIL wrap_to_0 got %0d want 0", lnk4.o_clk_cnt); end
      checks++; if (lnk4.o_clk_cnt !== model_cnt[3:0]) begin errors++; $display("FAIL wrap_model got %0d want %0d", lnk4.o_clk_cnt, model_cnt[3:0]); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rstn   = 1'b0;
      idle_inputs();
      lnk4.i_wen_to_link       = 1'b0;
      lnk4.i_token_to_link     = '0;
      lnk4.i_ready_to_link     = 1'b0;
      lnk4.i_wen_from_link     = 1'b0;
      lnk4.i_token_from_link   = '0;
      lnk4.i_clk_cnt_from_link = '0;
      lnk4.i_id_from_link      = '0;
      test_reset();
      test_fifo_order();
      test_full_overflow();
      test_full_push_pop();
      test_back_to_back();
      test_rx();
      test_reset_midop();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
